// File: rtl/misere_grid_pkg.sv
// Shared encodings and width helpers for the misere grid engine.
// Tile/result codes are fixed by the display front end; the FSM states are internal only.
package misere_grid_pkg;

    localparam logic [1:0] TILE_EMPTY = 2'b00;
    localparam logic [1:0] TILE_BLUE  = 2'b01;
    localparam logic [1:0] TILE_RED   = 2'b10;
    localparam logic [1:0] TILE_BAD   = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SCAN,
        ST_OVER
    } state_t;

    function automatic int unsigned pos_w(input int unsigned n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n * n + 1);
    endfunction

endpackage

// File: rtl/grid_run_detect.sv
// Combinational K-in-a-row test for runs starting at one cell, looking
// right, down, down-right and down-left.
module grid_run_detect
    import misere_grid_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned K = 3
) (
    input  logic [2*N*N-1:0]    board,
    input  logic [pos_w(N)-1:0] idx,
    output logic                hit
);

    localparam int unsigned CELLS = N * N;

    int unsigned c;
    int unsigned row;
    int unsigned col;
    logic [1:0]  t;
    logic        ok_r, ok_d, ok_dr, ok_dl;

    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int unsigned i);
        return (i < CELLS) ? b[2*i +: 2] : TILE_EMPTY;
    endfunction

    // Bounds are decided from row/column first so a run never wraps across a row edge.
    always_comb begin
        c     = 32'(idx);
        row   = c / N;
        col   = c % N;
        t     = cell_at(board, c);
        ok_r  = (col + K <= N);
        ok_d  = (row + K <= N);
        ok_dr = ok_r && ok_d;
        ok_dl = (col + 1 >= K) && ok_d;
        for (int unsigned j = 1; j < K; j++) begin
            if (cell_at(board, c + j) != t)           ok_r  = 1'b0;
            if (cell_at(board, c + j * N) != t)       ok_d  = 1'b0;
            if (cell_at(board, c + j * (N + 1)) != t) ok_dr = 1'b0;
            if (cell_at(board, c + j * (N - 1)) != t) ok_dl = 1'b0;
        end
        hit = (c < CELLS) && (t != TILE_EMPTY) && (ok_r || ok_d || ok_dr || ok_dl);
    end

endmodule

// File: rtl/misere_grid_engine.sv
// Wild Misere Red Tile Blue engine: accepts moves, scans the board one cell
// per cycle for K-in-a-row and reports win, loss or draw.
module misere_grid_engine
    import misere_grid_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned K      = 3,
    parameter int unsigned MISERE = 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                new_game,
    input  logic                move_valid,
    output logic                move_ready,
    input  logic [pos_w(N)-1:0] move_pos,
    input  logic [1:0]          move_tile,
    output logic                move_err,
    input  logic [pos_w(N)-1:0] rd_addr,
    output logic [1:0]          rd_data,
    output logic                turn,
    output logic [cnt_w(N)-1:0] move_count,
    output logic                game_over,
    output logic [1:0]          result
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned POS_W = pos_w(N);

    state_t             state, state_nxt;
    logic [2*CELLS-1:0] board;
    logic [POS_W-1:0]   scan_idx;
    logic               mover;
    logic               hit;
    logic               legal, take, accept, reject, scan_last, board_full;
    logic [1:0]         target_tile;

    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int unsigned i);
        return (i < CELLS) ? b[2*i +: 2] : TILE_EMPTY;
    endfunction

    grid_run_detect #(
        .N(N),
        .K(K)
    ) u_detect (
        .board(board),
        .idx  (scan_idx),
        .hit  (hit)
    );

    assign rd_data     = cell_at(board, 32'(rd_addr));
    assign target_tile = cell_at(board, 32'(move_pos));
    assign move_ready  = (state == ST_WAIT);

    always_comb begin
        legal      = (32'(move_pos) < CELLS) && (target_tile == TILE_EMPTY) &&
                     ((move_tile == TILE_BLUE) || (move_tile == TILE_RED));
        take       = move_valid && move_ready && !new_game;
        accept     = take && legal;
        reject     = take && !legal;
        scan_last  = (32'(scan_idx) == CELLS - 1);
        board_full = (32'(move_count) == CELLS);
        state_nxt  = state;
        unique case (state)
            ST_WAIT: if (accept) state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (hit)            state_nxt = ST_OVER;
                else if (scan_last) state_nxt = board_full ? ST_OVER : ST_WAIT;
            end
            ST_OVER: state_nxt = ST_OVER;
            default: state_nxt = ST_WAIT;
        endcase
        if (new_game) state_nxt = ST_WAIT;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_WAIT;
        else         state <= state_nxt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            board      <= '0;
            scan_idx   <= '0;
            mover      <= 1'b0;
            turn       <= 1'b0;
            move_count <= '0;
            game_over  <= 1'b0;
            result     <= RES_NONE;
            move_err   <= 1'b0;
        end else if (new_game) begin
            board      <= '0;
            scan_idx   <= '0;
            mover      <= 1'b0;
            turn       <= 1'b0;
            move_count <= '0;
            game_over  <= 1'b0;
            result     <= RES_NONE;
            move_err   <= 1'b0;
        end else begin
            move_err <= reject;
            if (accept) begin
                board[2*32'(move_pos) +: 2] <= move_tile;
                move_count <= move_count + 1'b1;
                mover      <= turn;
                scan_idx   <= '0;
            end
            if (state == ST_SCAN) begin
                // Wild rule: any completed run belongs to the player who just moved.
                if (hit) begin
                    game_over <= 1'b1;
                    if (MISERE != 0) result <= mover ? RES_P1 : RES_P2;
                    else             result <= mover ? RES_P2 : RES_P1;
                end else if (scan_last) begin
                    if (board_full) begin
                        game_over <= 1'b1;
                        result    <= RES_DRAW;
                    end else begin
                        turn <= ~turn;
                    end
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end
        end
    end

endmodule
